// File: rtl/sysid_checker.sv
// sysid_checker: reads the two sysid slave words over Avalon-MM and compares them.
// Optional stalled-read timeout is enabled by defining SYSID_CHECKER_TIMEOUT_EN.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1400146849,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  typedef enum logic [1:0] {
    IDLE,
    RD_ID,
    RD_TS,
    CMP
  } state_t;

  state_t      state_q, state_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic [31:0] id_val_q, id_val_d;
  logic [31:0] ts_val_q, ts_val_d;

`ifdef SYSID_CHECKER_TIMEOUT_EN
  localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

  logic        to_q, to_d;
  logic [15:0] cnt_q, cnt_d;
  logic        stall_hit;

  // A stalled read that has already waited its full budget aborts the check
  assign stall_hit = avm_waitrequest && (cnt_q == CntLast);
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  // Next-state and Avalon command decode
  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    id_ok_d     = id_ok_q;
    ts_ok_d     = ts_ok_q;
    id_val_d    = id_val_q;
    ts_val_d    = ts_val_q;
    avm_read    = 1'b0;
    avm_address = 1'b0;
`ifdef SYSID_CHECKER_TIMEOUT_EN
    to_d        = to_q;
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_ID;
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
`ifdef SYSID_CHECKER_TIMEOUT_EN
          to_d    = 1'b0;
          cnt_d   = '0;
`endif
        end
      end
      RD_ID, RD_TS: begin
        avm_read    = 1'b1;
        avm_address = (state_q == RD_TS);
        if (!avm_waitrequest) begin
          if (state_q == RD_ID) begin
            id_val_d = avm_readdata;
            state_d  = RD_TS;
          end else begin
            ts_val_d = avm_readdata;
            state_d  = CMP;
          end
`ifdef SYSID_CHECKER_TIMEOUT_EN
          cnt_d = '0;
        end else if (stall_hit) begin
          state_d = IDLE;
          to_d    = 1'b1;
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
`endif
        end
      end
      CMP: begin
        id_ok_d = (id_val_q == EXPECTED_ID);
        ts_ok_d = (ts_val_q == EXPECTED_TIMESTAMP);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers, cleared asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      id_ok_q  <= 1'b0;
      ts_ok_q  <= 1'b0;
      id_val_q <= '0;
      ts_val_q <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      id_ok_q  <= id_ok_d;
      ts_ok_q  <= ts_ok_d;
      id_val_q <= id_val_d;
      ts_val_q <= ts_val_d;
    end
  end

`ifdef SYSID_CHECKER_TIMEOUT_EN
  // Stall counter and abort flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      to_q  <= to_d;
      cnt_q <= cnt_d;
    end
  end

  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign id_ok    = id_ok_q;
  assign ts_ok    = ts_ok_q;
  assign id_value = id_val_q;
  assign ts_value = ts_val_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Self-checking bench for sysid_checker with a stalling sysid slave model.
// Timeout scenario runs on a second instance when SYSID_CHECKER_TIMEOUT_EN is set.
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1400146849;
  localparam int          BUDGET = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;
  logic        avm_address, avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  int checks = 0;
  int errors = 0;

  logic [31:0] word [2];
  int          stall_n [2];
  int          scnt;

  always #5 clock = ~clock;

  sysid_checker #(
    .EXPECTED_ID       (EXP_ID),
    .EXPECTED_TIMESTAMP(EXP_TS),
    .TIMEOUT_CYCLES    (255)
  ) u_dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .id_ok          (id_ok),
    .ts_ok          (ts_ok),
    .timeout        (timeout),
    .id_value       (id_value),
    .ts_value       (ts_value),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

`ifdef SYSID_CHECKER_TIMEOUT_EN
  logic        start2 = 1'b0;
  logic        busy2, done2, id_ok2, ts_ok2, timeout2;
  logic [31:0] id_value2, ts_value2;
  logic        avm_address2, avm_read2;

  sysid_checker #(
    .EXPECTED_ID       (EXP_ID),
    .EXPECTED_TIMESTAMP(EXP_TS),
    .TIMEOUT_CYCLES    (4)
  ) u_to (
    .clock          (clock),
    .reset          (reset),
    .start          (start2),
    .busy           (busy2),
    .done           (done2),
    .id_ok          (id_ok2),
    .ts_ok          (ts_ok2),
    .timeout        (timeout2),
    .id_value       (id_value2),
    .ts_value       (ts_value2),
    .avm_address    (avm_address2),
    .avm_read       (avm_read2),
    .avm_readdata   (32'd0),
    .avm_waitrequest(1'b1)
  );
`endif

  // Slave: stalls each read stall_n[addr] cycles, then returns word[addr]
  always_comb begin
    avm_waitrequest = avm_read && (scnt < stall_n[avm_address]);
    avm_readdata    = word[avm_address];
  end

  always @(posedge clock or posedge reset) begin
    if (reset) scnt <= 0;
    else if (avm_read && avm_waitrequest) scnt <= scnt + 1;
    else scnt <= 0;
  end

  function automatic logic [72:0] outs();
    return {busy, done, id_ok, ts_ok, timeout,
            avm_read, avm_address, id_value, ts_value};
  endfunction

  // One full check from an idle negedge; expectations from the slave words
  task automatic run_check(input logic [31:0] w0, input logic [31:0] w1,
                           input int s0, input int s1,
                           input bit poke, input bit chain,
                           input string nm);
    int   m;
    logic pr, pa, pw;
    logic eid, ets;
    eid = (w0 == EXP_ID);
    ets = (w1 == EXP_TS);
    word[0] = w0;
    word[1] = w1;
    stall_n[0] = s0;
    stall_n[1] = s1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    m = 1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start got %b want 1", nm, busy);
    end
    while (!done && m < BUDGET) begin
      pr = avm_read;
      pa = avm_address;
      pw = avm_waitrequest;
      start = poke && (m == 2);
      @(negedge clock);
      m++;
      if (pw) begin
        checks++;
        if (avm_read !== pr || avm_address !== pa) begin
          errors++;
          $display("FAIL %s hold got rd=%b a=%b want rd=%b a=%b",
                   nm, avm_read, avm_address, pr, pa);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (m !== 4 + s0 + s1) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", nm, m, 4 + s0 + s1);
    end
    checks++;
    if ({id_ok, ts_ok, timeout, busy} !== {eid, ets, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s flags got %b%b%b%b want %b%b00",
               nm, id_ok, ts_ok, timeout, busy, eid, ets);
    end
    checks++;
    if (id_value !== w0 || ts_value !== w1) begin
      errors++;
      $display("FAIL %s values got %h/%h want %h/%h",
               nm, id_value, ts_value, w0, w1);
    end
    if (!chain) begin
      @(negedge clock);
      checks++;
      if ({done, busy, id_ok, ts_ok} !== {2'b00, eid, ets}) begin
        errors++;
        $display("FAIL %s after_done got d=%b b=%b %b%b want 00 %b%b",
                 nm, done, busy, id_ok, ts_ok, eid, ets);
      end
    end
  endtask

  task automatic test_reset();
    word[0] = EXP_ID;
    word[1] = EXP_TS;
    stall_n[0] = 0;
    stall_n[1] = 0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL reset_state got %h want 0", outs());
    end
    reset = 1'b0;
  endtask

  task automatic test_zero_wait();
    run_check(EXP_ID, EXP_TS, 0, 0, 0, 0, "zero_wait");
  endtask

  task automatic test_mismatch();
    run_check(EXP_ID, 32'h12345678, 0, 0, 0, 0, "mismatch");
  endtask

  task automatic test_stall();
    run_check(EXP_ID, EXP_TS, 5, 0, 0, 0, "stall_id");
    run_check(32'h00000001, EXP_TS, 0, 3, 0, 0, "stall_ts");
  endtask

  task automatic test_random();
    logic [31:0] w0, w1;
    for (int i = 0; i < 20; i++) begin
      w0 = $urandom_range(0, 1) ? EXP_ID : $urandom;
      w1 = $urandom_range(0, 1) ? EXP_TS : $urandom;
      run_check(w0, w1, $urandom_range(0, 3), $urandom_range(0, 3),
                0, 0, "random");
    end
  endtask

  task automatic test_busy_ignore();
    run_check(EXP_ID, EXP_TS, 1, 1, 1, 0, "busy_ignore");
  endtask

  task automatic test_back_to_back();
    run_check(EXP_ID, 32'hDEADBEEF, 0, 0, 0, 1, "b2b_first");
    run_check(32'h0000ABCD, EXP_TS, 0, 1, 0, 0, "b2b_second");
  endtask

  task automatic test_reset_mid();
    word[0] = 32'h11111111;
    word[1] = EXP_TS;
    stall_n[0] = 0;
    stall_n[1] = 2;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    checks++;
    if ({busy, avm_read, avm_address} !== 3'b111) begin
      errors++;
      $display("FAIL mid_in_rd_ts got %b want 111",
               {busy, avm_read, avm_address});
    end
    reset = 1'b1;
    #1;
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL mid_reset got %h want 0", outs());
    end
    @(negedge clock);
    reset = 1'b0;
    run_check(EXP_ID, EXP_TS, 0, 0, 0, 0, "after_reset");
  endtask

`ifdef SYSID_CHECKER_TIMEOUT_EN
  task automatic test_timeout();
    int m;
    start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    m = 1;
    while (!done2 && m < BUDGET) begin
      @(negedge clock);
      m++;
    end
    checks++;
    if (m !== 5) begin
      errors++;
      $display("FAIL timeout_latency got %0d want 5", m);
    end
    checks++;
    if ({timeout2, id_ok2, ts_ok2, avm_read2, busy2} !== 5'b10000) begin
      errors++;
      $display("FAIL timeout_flags got %b want 10000",
               {timeout2, id_ok2, ts_ok2, avm_read2, busy2});
    end
    @(negedge clock);
    checks++;
    if ({done2, timeout2} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_hold got %b want 01", {done2, timeout2});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_wait();
    test_mismatch();
    test_stall();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
`ifdef SYSID_CHECKER_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
